// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: FSM states,
// frame geometry and bit positions of the memory-mapped read word.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam int PS2_DATA_BITS = 8;

    localparam int VALID = 15;
    localparam int OVF   = 14;
    localparam int FERR  = 13;

    // Odd parity holds when data bits plus the parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Generic synchronous first-word-fall-through FIFO. The head entry is
// always visible on o_dout; pointers carry one extra wrap bit.
module ps2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin synchroniser, frame FSM, timeout and
// sticky flags in front of a FWFT byte FIFO. Optional PS2_PARITY_CHECK_EN.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ps2_clk,
    input  logic        i_ps2_data,
    input  logic        i_ren,
    output logic [15:0] o_data
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int BW = $clog2(PS2_DATA_BITS);

    logic [1:0]               r_clk_sync;
    logic [1:0]               r_data_sync;
    logic                     r_clk_prev;
    ps2_state_e               r_state;
    ps2_state_e               w_state_nxt;
    logic [PS2_DATA_BITS-1:0] r_shift;
    logic [BW-1:0]            r_bitcnt;
    logic                     r_parity;
    logic [TW-1:0]            r_tcnt;
    logic                     r_push;
    logic                     r_ovf;
    logic                     r_ferr;
    logic                     w_fall;
    logic                     w_bit;
    logic                     w_timeout;
    logic                     w_push;
    logic                     w_ferr_stop;
    logic                     w_par_ok;
    logic                     w_empty;
    logic                     w_full;
    logic [7:0]               w_dout;

    // Idle-high bus: presetting to 1 keeps reset release from looking like a falling edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign w_fall    = r_clk_prev && !r_clk_sync[1];
    assign w_bit     = r_data_sync[1];
    assign w_timeout = (r_state != IDLE) && !w_fall && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
    assign w_par_ok = odd_parity_ok(r_shift, r_parity);
`else
    logic w_unused_parity;
    assign w_par_ok        = 1'b1;
    assign w_unused_parity = r_parity;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_ferr_stop = 1'b0;
        if (w_timeout) begin
            w_state_nxt = IDLE;
        end else if (w_fall) begin
            case (r_state)
                IDLE:    if (!w_bit) w_state_nxt = DATA;
                DATA:    if (r_bitcnt == BW'(PS2_DATA_BITS - 1)) w_state_nxt = PARITY;
                PARITY:  w_state_nxt = STOP;
                STOP: begin
                    w_state_nxt = IDLE;
                    if (w_bit && w_par_ok) w_push      = 1'b1;
                    else                   w_ferr_stop = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_parity <= 1'b0;
            r_tcnt   <= '0;
            r_push   <= 1'b0;
        end else begin
            r_push <= w_push;
            if (w_fall || r_state == IDLE || w_timeout) r_tcnt <= '0;
            else                                        r_tcnt <= r_tcnt + 1'b1;
            if (w_fall) begin
                case (r_state)
                    IDLE: if (!w_bit) begin
                        r_shift  <= '0;
                        r_bitcnt <= '0;
                    end
                    DATA: begin
                        r_shift  <= {w_bit, r_shift[PS2_DATA_BITS-1:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    PARITY:  r_parity <= w_bit;
                    default: ;
                endcase
            end
        end
    end

    // r_shift is stable during the push cycle: the next frame cannot start for several cycles.
    ps2_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (r_push),
        .i_pop   (i_ren),
        .i_din   (r_shift),
        .o_dout  (w_dout),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Set wins over the ren clear in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ovf  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (r_push && w_full && !i_ren) r_ovf <= 1'b1;
            else if (i_ren)                 r_ovf <= 1'b0;
            if (w_ferr_stop || w_timeout)   r_ferr <= 1'b1;
            else if (i_ren)                 r_ferr <= 1'b0;
        end
    end

    always_comb begin
        o_data        = '0;
        o_data[VALID] = !w_empty;
        o_data[OVF]   = r_ovf;
        o_data[FERR]  = r_ferr;
        o_data[7:0]   = w_empty ? 8'h00 : w_dout;
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx; PS/2 clock and timeout are scaled down
// (40-cycle bit period, 500-cycle timeout) to keep the run short.
module tb_ps2_rx;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 500;
    localparam int HP      = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        ren = 1'b0;
    logic [15:0] o_data;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  sb[$];
    logic        exp_ovf = 1'b0;
    logic        exp_ferr = 1'b0;
    logic [15:0] exp;

    ps2_rx #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .i_ren      (ren),
        .o_data     (o_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_word();
        if (sb.size() == 0) return {1'b0, exp_ovf, exp_ferr, 13'h0};
        return {1'b1, exp_ovf, exp_ferr, 5'h0, sb[0]};
    endfunction

    function automatic void model_pop();
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
    endfunction

    task automatic ps2_bit(input logic b, input bit pop_at_fall);
        @(negedge clk);
        ps2_data = b;
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b0;
        if (pop_at_fall) begin
            // ren lands on the cycle the stop-bit byte is written.
            repeat (3) @(negedge clk);
            ren = 1'b1;
            @(negedge clk);
            ren = 1'b0;
            repeat (HP - 4) @(negedge clk);
        end else begin
            repeat (HP) @(negedge clk);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_at_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(par, 1'b0);
        ps2_bit(1'b1, pop_at_stop);
        repeat (10) @(negedge clk);
        if (pop_at_stop) model_pop();
`ifdef PS2_PARITY_CHECK_EN
        if (bad_par) exp_ferr = 1'b1;
        else if (sb.size() < DEPTH) sb.push_back(b);
        else exp_ovf = 1'b1;
`else
        if (sb.size() < DEPTH) sb.push_back(b);
        else exp_ovf = 1'b1;
`endif
    endtask

    task automatic do_pop();
        @(negedge clk);
        ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
        model_pop();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (o_data !== 16'h0000) begin
            errors++; $display("FAIL reset_held: got %h expected %h", o_data, 16'h0000);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_data !== 16'h0000) begin
            errors++; $display("FAIL reset_release: got %h expected %h", o_data, 16'h0000);
        end
    endtask

    task automatic test_single();
        send_frame(8'h1C, 1'b0, 1'b0);
        exp = exp_word();
        checks++;
        if (o_data !== exp) begin
            errors++; $display("FAIL single_1c: got %h expected %h", o_data, exp);
        end
        do_pop();
        exp = exp_word();
        checks++;
        if (o_data !== exp) begin
            errors++; $display("FAIL single_pop: got %h expected %h", o_data, exp);
        end
        do_pop();
        checks++;
        if (o_data !== 16'h0000) begin
            errors++; $display("FAIL pop_empty: got %h expected %h", o_data, 16'h0000);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            exp = exp_word();
            checks++;
            if (o_data !== exp) begin
                errors++; $display("FAIL ovf_read%0d: got %h expected %h", i, o_data, exp);
            end
            do_pop();
        end
        checks++;
        if (o_data !== 16'h0000) begin
            errors++; $display("FAIL ovf_drained: got %h expected %h", o_data, 16'h0000);
        end
    endtask

    task automatic test_parity();
        send_frame(8'h1C, 1'b1, 1'b0);
        exp = exp_word();
        checks++;
        if (o_data !== exp) begin
            errors++; $display("FAIL bad_parity: got %h expected %h", o_data, exp);
        end
        while (sb.size() != 0 || exp_ferr) do_pop();
        checks++;
        if (o_data !== 16'h0000) begin
            errors++; $display("FAIL parity_clear: got %h expected %h", o_data, 16'h0000);
        end
    endtask

    task automatic test_timeout();
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
        repeat (TIMEOUT + 50) @(negedge clk);
        exp_ferr = 1'b1;
        exp = exp_word();
        checks++;
        if (o_data !== exp) begin
            errors++; $display("FAIL timeout_ferr: got %h expected %h", o_data, exp);
        end
        send_frame(8'h5A, 1'b0, 1'b0);
        exp = exp_word();
        checks++;
        if (o_data !== exp) begin
            errors++; $display("FAIL timeout_next: got %h expected %h", o_data, exp);
        end
        do_pop();
        exp = exp_word();
        checks++;
        if (o_data !== exp) begin
            errors++; $display("FAIL timeout_pop: got %h expected %h", o_data, exp);
        end
    endtask

    task automatic test_full_pushpop();
        for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
        send_frame(8'h18, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            exp = exp_word();
            checks++;
            if (o_data !== exp) begin
                errors++; $display("FAIL full_pp_read%0d: got %h expected %h", i, o_data, exp);
            end
            do_pop();
        end
        checks++;
        if (o_data !== 16'h0000) begin
            errors++; $display("FAIL full_pp_drained: got %h expected %h", o_data, 16'h0000);
        end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h21, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        send_frame(8'h23, 1'b0, 1'b0);
        exp = exp_word();
        checks++;
        if (o_data !== exp) begin
            errors++; $display("FAIL mid_queued: got %h expected %h", o_data, exp);
        end
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
        @(negedge clk);
        checks++;
        if (o_data !== 16'h0000) begin
            errors++; $display("FAIL mid_reset: got %h expected %h", o_data, 16'h0000);
        end
        send_frame(8'h34, 1'b0, 1'b0);
        exp = exp_word();
        checks++;
        if (o_data !== exp) begin
            errors++; $display("FAIL mid_next: got %h expected %h", o_data, exp);
        end
        do_pop();
        checks++;
        if (o_data !== 16'h0000) begin
            errors++; $display("FAIL mid_pop: got %h expected %h", o_data, 16'h0000);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_parity();
        test_timeout();
        test_full_pushpop();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
